adder16_accum_ctrl: RTL and testbench

- Sequencing stage wrapped around the 16-bit flag-producing adder.
- Drives the adder operands: x is the running accumulator, y is the incoming operand.
- Consumes the adder's sum and flags, and reduces a valid/ready operand stream, terminated by a last marker, into one registered result with a status word.
- Sits between the operand source and whatever reads the adder's results, such as a register file or status register.

---
 rtl/adder16_pkg.sv | 11 +
 rtl/adder16_accum_ctrl_if.sv | 29 ++
 rtl/adder16_accum_ctrl.sv | 70 +++++++
 tb/tb_adder16_accum_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/adder16_pkg.sv
// adder16_pkg: flag bit positions and control-state encoding shared by the adder and its sequencing stage
package adder16_pkg;
  localparam int FLG_SIGN = 0;
  localparam int FLG_ZERO = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_PARITY = 3;
  localparam int FLG_OVF = 4;
  localparam int FLG_W = 5;
  localparam logic [0:0] ACC = 1'b0;
  localparam logic [0:0] DONE = 1'b1;
endpackage

// File: rtl/adder16_accum_ctrl_if.sv
// adder16_accum_ctrl_if: operand stream (in_*), adder round trip (add_*) and result stream (res_*); slave = sequencing stage, master = its environment
interface adder16_accum_ctrl_if #(parameter int DW = 16, parameter int CNT_W = 8);
  import adder16_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_data;
  logic in_last;
  logic [DW-1:0] add_x;
  logic [DW-1:0] add_y;
  logic [DW-1:0] add_z;
  logic add_sign;
  logic add_zero;
  logic add_carry;
  logic add_parity;
  logic add_overflow;
  logic res_valid;
  logic res_ready;
  logic [DW-1:0] res_data;
  logic [FLG_W-1:0] res_flags;
  logic [CNT_W-1:0] res_count;
  modport slave (
    input in_valid, in_data, in_last, add_z, add_sign, add_zero, add_carry, add_parity, add_overflow, res_ready,
    output in_ready, add_x, add_y, res_valid, res_data, res_flags, res_count
  );
  modport master (
    output in_valid, in_data, in_last, add_z, add_sign, add_zero, add_carry, add_parity, add_overflow, res_ready,
    input in_ready, add_x, add_y, res_valid, res_data, res_flags, res_count
  );
endinterface

// File: rtl/adder16_accum_ctrl.sv
// adder16_accum_ctrl: reduces a last-terminated operand stream through an external adder into one result with {ovf,parity,carry,zero,sign} and saturating beat count; ports clk, rst_n (sync active-low), bus (slave)
module adder16_accum_ctrl
  import adder16_pkg::*;
#(
  parameter int DW = 16,
  parameter int CNT_W = 8,
  parameter int STICKY = 1
) (
  input logic clk,
  input logic rst_n,
  adder16_accum_ctrl_if.slave bus
);
  localparam logic SK = STICKY != 0;
  logic [0:0] state;
  logic [DW-1:0] acc_q;
  logic c_st;
  logic v_st;
  logic [CNT_W-1:0] count;
  logic acc_en;
  logic c_next;
  logic v_next;
  logic [CNT_W-1:0] count_next;
  logic [FLG_W-1:0] flags_next;
  assign bus.in_ready = state == ACC;
  assign bus.add_x = state == ACC ? acc_q : '0;
  assign bus.add_y = bus.in_data;
  assign acc_en = bus.in_valid && bus.in_ready;
  assign c_next = (SK & c_st) | bus.add_carry;
  assign v_next = (SK & v_st) | bus.add_overflow;
  assign count_next = &count ? count : count + 1'b1;
  always_comb begin
    flags_next = '0;
    flags_next[FLG_SIGN] = bus.add_sign;
    flags_next[FLG_ZERO] = bus.add_zero;
    flags_next[FLG_CARRY] = c_next;
    flags_next[FLG_PARITY] = bus.add_parity;
    flags_next[FLG_OVF] = v_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
      acc_q <= '0;
      c_st <= 1'b0;
      v_st <= 1'b0;
      count <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_flags <= '0;
      bus.res_count <= '0;
    end else begin
      if (acc_en) begin
        acc_q <= bus.in_last ? '0 : bus.add_z;
        c_st <= bus.in_last ? 1'b0 : c_next;
        v_st <= bus.in_last ? 1'b0 : v_next;
        count <= bus.in_last ? '0 : count_next;
        if (bus.in_last) begin
          bus.res_data <= bus.add_z;
          bus.res_flags <= flags_next;
          bus.res_count <= count_next;
          bus.res_valid <= 1'b1;
          state <= DONE;
        end
      end
      if (state == DONE && bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
        state <= ACC;
      end
    end
  end
endmodule

// File: tb/tb_adder16_accum_ctrl.sv
// tb_adder16_accum_ctrl: table-driven check of the accumulate stage with a behavioural adder; three instances (sticky, non-sticky, 2-bit count)
module tb_adder16_accum_ctrl;
  import adder16_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  adder16_accum_ctrl_if #(.DW(16), .CNT_W(8)) m ();
  adder16_accum_ctrl_if #(.DW(16), .CNT_W(8)) s0 ();
  adder16_accum_ctrl_if #(.DW(16), .CNT_W(2)) c2 ();
  adder16_accum_ctrl #(.DW(16), .CNT_W(8), .STICKY(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m));
  adder16_accum_ctrl #(.DW(16), .CNT_W(8), .STICKY(0)) dut_s0 (.clk(clk), .rst_n(rst_n), .bus(s0));
  adder16_accum_ctrl #(.DW(16), .CNT_W(2), .STICKY(1)) dut_c2 (.clk(clk), .rst_n(rst_n), .bus(c2));
  function automatic logic [20:0] am(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    logic [15:0] z;
    s = {1'b0, x} + {1'b0, y};
    z = s[15:0];
    return {(x[15] == y[15]) && (z[15] != x[15]), ~^z, s[16], z == 16'h0, z[15], z};
  endfunction
  assign {m.add_overflow, m.add_parity, m.add_carry, m.add_zero, m.add_sign, m.add_z} = am(m.add_x, m.add_y);
  assign {s0.add_overflow, s0.add_parity, s0.add_carry, s0.add_zero, s0.add_sign, s0.add_z} = am(s0.add_x, s0.add_y);
  assign {c2.add_overflow, c2.add_parity, c2.add_carry, c2.add_zero, c2.add_sign, c2.add_z} = am(c2.add_x, c2.add_y);
  assign s0.in_valid = m.in_valid;
  assign s0.in_data = m.in_data;
  assign s0.in_last = m.in_last;
  assign s0.res_ready = m.res_ready;
  assign c2.in_valid = m.in_valid;
  assign c2.in_data = m.in_data;
  assign c2.in_last = m.in_last;
  assign c2.res_ready = m.res_ready;
  typedef struct {
    int n;
    logic [4:0][15:0] d;
    logic [15:0] ed;
    logic [4:0] ef;
    logic [4:0] ef0;
    logic [7:0] ec;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic beat(input logic [15:0] d, input logic l);
    int n = 0;
    m.in_valid = 1'b1;
    m.in_data = d;
    m.in_last = l;
    while (!m.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("beat_ready_timeout", {31'b0, m.in_ready}, 32'd1);
    @(negedge clk);
    m.in_valid = 1'b0;
    m.in_data = 16'hxxxx;
    m.in_last = 1'bx;
  endtask
  task automatic get_res(input string tag, input logic [15:0] ed, input logic [4:0] ef, input logic [4:0] ef0,
                         input logic [7:0] ec);
    int n = 0;
    while (!m.res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'b0, m.res_valid}, 32'd1);
    chk({tag, "_data"}, {16'b0, m.res_data}, {16'b0, ed});
    chk({tag, "_flags"}, {27'b0, m.res_flags}, {27'b0, ef});
    chk({tag, "_count"}, {24'b0, m.res_count}, {24'b0, ec});
    chk({tag, "_flags_nosticky"}, {27'b0, s0.res_flags}, {27'b0, ef0});
    chk({tag, "_data_cnt2"}, {16'b0, c2.res_data}, {16'b0, ed});
    chk({tag, "_count_cnt2"}, {30'b0, c2.res_count}, ec > 8'd3 ? 32'd3 : {24'b0, ec});
    chk({tag, "_ready_low"}, {31'b0, m.in_ready}, 32'd0);
    if (m.res_ready) begin
      @(negedge clk);
      chk({tag, "_valid_1cyc"}, {31'b0, m.res_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'b0, m.in_ready}, 32'd1);
    end
  endtask
  initial begin
    tv[0] = '{2, {48'h0, 16'h8000, 16'h8FFF}, 16'h0FFF, 5'b11100, 5'b11100, 8'd2};
    tv[1] = '{2, {48'h0, 16'h0002, 16'hFAFE}, 16'hFB00, 5'b00001, 5'b00001, 8'd2};
    tv[2] = '{2, {48'h0, 16'h5555, 16'hAAAA}, 16'hFFFF, 5'b01001, 5'b01001, 8'd2};
    tv[3] = '{2, {48'h0, 16'hFFFF, 16'h0001}, 16'h0000, 5'b01110, 5'b01110, 8'd2};
    tv[4] = '{3, {32'h0, 16'h0001, 16'h0001, 16'hFFFF}, 16'h0001, 5'b00100, 5'b00000, 8'd3};
    tv[5] = '{5, {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001}, 16'h0005, 5'b01000, 5'b01000, 8'd5};
    tv[6] = '{1, {64'h0, 16'h0003}, 16'h0003, 5'b01000, 5'b01000, 8'd1};
    m.in_valid = 1'b0;
    m.in_data = '0;
    m.in_last = 1'b0;
    m.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", {31'b0, m.res_valid}, 32'd0);
    chk("rst_data", {16'b0, m.res_data}, 32'd0);
    chk("rst_flags", {27'b0, m.res_flags}, 32'd0);
    chk("rst_count", {24'b0, m.res_count}, 32'd0);
    chk("rst_ready", {31'b0, m.in_ready}, 32'd1);
    chk("rst_addx", {16'b0, m.add_x}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < tv[i].n; b++) beat(tv[i].d[b], b == tv[i].n - 1);
      get_res($sformatf("v%0d", i), tv[i].ed, tv[i].ef, tv[i].ef0, tv[i].ec);
    end
    m.res_ready = 1'b0;
    beat(16'h1234, 1'b1);
    get_res("bp", 16'h1234, 5'b00000, 5'b00000, 8'd1);
    for (int k = 0; k < 3; k++) begin
      m.in_valid = 1'b1;
      m.in_data = 16'hFFFF;
      m.in_last = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), {31'b0, m.res_valid}, 32'd1);
      chk($sformatf("bp_hold_data%0d", k), {16'b0, m.res_data}, 32'h1234);
      chk($sformatf("bp_hold_count%0d", k), {24'b0, m.res_count}, 32'd1);
      chk($sformatf("bp_hold_ready%0d", k), {31'b0, m.in_ready}, 32'd0);
    end
    m.in_valid = 1'b0;
    m.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_valid", {31'b0, m.res_valid}, 32'd0);
    chk("bp_handoff_ready", {31'b0, m.in_ready}, 32'd1);
    chk("bp_keep_data", {16'b0, m.res_data}, 32'h1234);
    beat(16'h0002, 1'b1);
    get_res("bp_next", 16'h0002, 5'b00000, 5'b00000, 8'd1);
    beat(16'h0100, 1'b0);
    beat(16'h0200, 1'b0);
    chk("pre_rst_addx", {16'b0, m.add_x}, 32'h0300);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, m.res_valid}, 32'd0);
    chk("mid_rst_addx", {16'b0, m.add_x}, 32'd0);
    chk("mid_rst_ready", {31'b0, m.in_ready}, 32'd1);
    beat(16'h0003, 1'b1);
    get_res("post_rst", 16'h0003, 5'b01000, 5'b01000, 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
